// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//
// Built-in self test engine for a two-read / one-write register file.
//
// A run has three phases:
//   WRITE : every address 0..DEPTH-1 is written once with pat(addr).
//           An optional single-bit fault (bit 0 flipped) can be injected at one
//           address to prove that the checker sees it.
//   READ  : the lower and upper halves of the file are read in parallel, one
//           pair per cycle, and each port is compared with the clean pattern.
//   DONE  : results are held until the next start.
//
// A complete run takes 1.5 * DEPTH cycles from the accepting edge to done.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a run (accepted only in IDLE or DONE)
//   mode              pattern select, latched on an accepted start
//   inj_en, inj_addr  fault injection control, latched on an accepted start
//   wr_en/addr/data   register-file write port (driven only in WRITE)
//   rd_addr0/1        register-file read addresses (driven only in READ)
//   rd_data0/1        combinational read data from the register file
//   busy, done, pass  run status
//   err_cnt           number of mismatching reads in the current/last run
//   fail_addr         first mismatching address of the current/last run
//   state_o           raw FSM state: IDLE=11, WRITE=01, READ=00, DONE=10
// -----------------------------------------------------------------------------
module regfile_bist #(
   parameter int          DATA_W = 32,
   parameter int          ADDR_W = 5,
   parameter logic [31:0] SEED   = 32'hFFFF000F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              inj_en,
   input  logic [ADDR_W-1:0] inj_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] rd_addr0,
   output logic [ADDR_W-1:0] rd_addr1,
   input  logic [DATA_W-1:0] rd_data0,
   input  logic [DATA_W-1:0] rd_data1,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [1:0]        state_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int ERR_W = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] CNT_WR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_RD_LAST = ADDR_W'(DEPTH / 2 - 1);

   // Seed truncated (or zero-extended) to the data width.
   localparam logic [DATA_W-1:0] SEED_T = DATA_W'(SEED);

   // Repeated 2'b10 pattern: odd bit positions set, even positions clear.
   function automatic logic [DATA_W-1:0] checker_base();
      logic [DATA_W-1:0] b;
      b = '0;
      for (int i = 0; i < DATA_W; i++) begin
         b[i] = i[0];
      end
      return b;
   endfunction

   localparam logic [DATA_W-1:0] CHK = checker_base();

   // Encoding is visible on state_o, so the values are fixed.
   typedef enum logic [1:0] {
      S_READ  = 2'b00,
      S_WRITE = 2'b01,
      S_DONE  = 2'b10,
      S_IDLE  = 2'b11
   } state_t;

   // Test pattern for address a under pattern select m.
   function automatic logic [DATA_W-1:0] pat(input logic [1:0]        m,
                                             input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] a_ext;
      a_ext = DATA_W'(a);
      case (m)
         2'b00:   pat = SEED_T - a_ext;
         2'b01:   pat = a_ext;
         2'b10:   pat = a[0] ? ~CHK : CHK;
         default: pat = ~a_ext;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [1:0]        r_mode;
   logic              r_inj_en;
   logic [ADDR_W-1:0] r_inj_addr;
   logic [ERR_W-1:0]  r_err_cnt;
   logic [ADDR_W-1:0] r_fail_addr;

   // ---------------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------------
   state_t            w_state_nxt;
   logic              w_start_acc;
   logic              w_wr_last;
   logic              w_rd_last;
   logic [ADDR_W-1:0] w_rd_addr0;
   logic [ADDR_W-1:0] w_rd_addr1;
   logic              w_mis0;
   logic              w_mis1;
   logic [ERR_W-1:0]  w_err_inc;
   logic              w_inj_hit;

   assign w_wr_last = (r_cnt == CNT_WR_LAST);
   assign w_rd_last = (r_cnt == CNT_RD_LAST);

   // The read sweep pairs address i of the lower half with address i of the
   // upper half, so DEPTH/2 cycles cover the whole file.
   assign w_rd_addr0 = {1'b0, r_cnt[ADDR_W-2:0]};
   assign w_rd_addr1 = {1'b1, r_cnt[ADDR_W-2:0]};

   // Comparisons always use the clean pattern, so an injected fault shows up
   // as a mismatch.
   assign w_mis0    = (r_state == S_READ) && (rd_data0 != pat(r_mode, w_rd_addr0));
   assign w_mis1    = (r_state == S_READ) && (rd_data1 != pat(r_mode, w_rd_addr1));
   assign w_err_inc = ERR_W'(w_mis0) + ERR_W'(w_mis1);

   assign w_inj_hit = r_inj_en && (r_cnt == r_inj_addr);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_wr_last) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (w_rd_last) begin
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (all buses are forced to zero outside their own phase)
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr0 = '0;
      rd_addr1 = '0;
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_WRITE: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_addr = r_cnt;
            wr_data = pat(r_mode, r_cnt) ^ DATA_W'(w_inj_hit);
         end
         S_READ: begin
            busy     = 1'b1;
            rd_addr0 = w_rd_addr0;
            rd_addr1 = w_rd_addr1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign pass      = done && (r_err_cnt == '0);
   assign err_cnt   = r_err_cnt;
   assign fail_addr = r_fail_addr;
   assign state_o   = r_state;

   // ---------------------------------------------------------------------------
   // Datapath: run configuration, address counter and result capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_mode      <= '0;
         r_inj_en    <= 1'b0;
         r_inj_addr  <= '0;
         r_err_cnt   <= '0;
         r_fail_addr <= '0;
      end else if (w_start_acc) begin
         r_cnt       <= '0;
         r_mode      <= mode;
         r_inj_en    <= inj_en;
         r_inj_addr  <= inj_addr;
         r_err_cnt   <= '0;
         r_fail_addr <= '0;
      end else if (r_state == S_WRITE) begin
         r_cnt <= w_wr_last ? '0 : r_cnt + ADDR_W'(1);
      end else if (r_state == S_READ) begin
         r_cnt <= w_rd_last ? '0 : r_cnt + ADDR_W'(1);
         // At most DEPTH reads happen per run, so the ADDR_W+1 bit counter
         // cannot wrap.
         r_err_cnt <= r_err_cnt + w_err_inc;
         // An error count of zero means no mismatch has been captured yet;
         // port 0 wins when both ports mismatch in the same cycle.
         if ((r_err_cnt == '0) && (w_mis0 || w_mis1)) begin
            r_fail_addr <= w_mis0 ? w_rd_addr0 : w_rd_addr1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_bist.sv
// -----------------------------------------------------------------------------
// tb_regfile_bist
//
// Self-checking bench for regfile_bist (DATA_W=32, ADDR_W=5).
// Surrounds the DUT with an ideal 32-entry register file that can be given
// stuck-at-0 / stuck-at-1 bit faults on selected addresses. Expected write
// data and run results come from a reference model that walks the register
// file address by address with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_regfile_bist;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
   localparam int HALF   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        mode;
   logic              inj_en;
   logic [ADDR_W-1:0] inj_addr;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr0;
   logic [ADDR_W-1:0] rd_addr1;
   logic [DATA_W-1:0] rd_data0;
   logic [DATA_W-1:0] rd_data1;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W:0]   err_cnt;
   logic [ADDR_W-1:0] fail_addr;
   logic [1:0]        state_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_bist #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .SEED   (32'hFFFF000F)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .inj_en    (inj_en),
      .inj_addr  (inj_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr0  (rd_addr0),
      .rd_addr1  (rd_addr1),
      .rd_data0  (rd_data0),
      .rd_data1  (rd_data1),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_cnt   (err_cnt),
      .fail_addr (fail_addr),
      .state_o   (state_o)
   );

   // ---------------------------------------------------------------------------
   // Register file environment with optional stuck bits
   // ---------------------------------------------------------------------------
   logic [31:0]       rf [DEPTH];
   logic [31:0]       s0_mask;
   logic [31:0]       s1_mask;
   logic [ADDR_W-1:0] fault_a;
   logic [ADDR_W-1:0] fault_b;
   logic              fault_all;

   always @(posedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
   end

   always_comb begin
      rd_data0 = rf[rd_addr0];
      if (fault_all || rd_addr0 == fault_a || rd_addr0 == fault_b)
         rd_data0 = (rd_data0 & ~s0_mask) | s1_mask;
      rd_data1 = rf[rd_addr1];
      if (fault_all || rd_addr1 == fault_a || rd_addr1 == fault_b)
         rd_data1 = (rd_data1 & ~s0_mask) | s1_mask;
   end

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] ref_pat(input logic [1:0] m, input int a);
      case (m)
         2'd0:    return 32'hFFFF000F - 32'(a);
         2'd1:    return 32'(a);
         2'd2:    return (a % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555;
         default: return ~32'(a);
      endcase
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] stored, input int a);
      if (fault_all || a == int'(fault_a) || a == int'(fault_b))
         return (stored & ~s0_mask) | s1_mask;
      return stored;
   endfunction

   // Walks the read sweep: pair i reads address i and address i+HALF.
   task automatic model_run(input logic [1:0] m, input logic ie, input logic [4:0] ia,
                            output int exp_err, output int exp_fail);
      bit          found;
      int          a;
      logic [31:0] stored;
      exp_err  = 0;
      exp_fail = 0;
      found    = 0;
      for (int i = 0; i < HALF; i++) begin
         for (int p = 0; p < 2; p++) begin
            a      = i + p * HALF;
            stored = ref_pat(m, a) ^ ((ie && a == int'(ia)) ? 32'h1 : 32'h0);
            if (ref_read(stored, a) != ref_pat(m, a)) begin
               exp_err++;
               if (!found) begin
                  found    = 1;
                  exp_fail = a;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      s0_mask   = '0;
      s1_mask   = '0;
      fault_a   = '0;
      fault_b   = '0;
      fault_all = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " ctl"}, {state_o, busy, done, pass, wr_en}, {2'b11, 4'b0});
      check({tag, " bus"}, {wr_addr, wr_data, rd_addr0, rd_addr1}, 64'h0);
      check({tag, " res"}, {err_cnt, fail_addr}, 64'h0);
   endtask

   // One full run from IDLE or DONE, checking every cycle against the model.
   task automatic run_test(input string name, input logic [1:0] m, input logic ie,
                           input logic [4:0] ia, input bit noisy);
      int          exp_err;
      int          exp_fail;
      logic [31:0] exp_wd;
      model_run(m, ie, ia, exp_err, exp_fail);
      @(negedge clk);
      start    = 1'b1;
      mode     = m;
      inj_en   = ie;
      inj_addr = ia;
      @(negedge clk);
      // Scramble the configuration inputs: the DUT must use its latched copy.
      mode     = 2'($urandom_range(3));
      inj_en   = 1'($urandom_range(1));
      inj_addr = 5'($urandom_range(DEPTH - 1));
      for (int c = 0; c < DEPTH + HALF; c++) begin
         if (c > 0) @(negedge clk);
         start = noisy && (c == 5 || c == 40);
         if (c < DEPTH) begin
            exp_wd = ref_pat(m, c) ^ ((ie && c == int'(ia)) ? 32'h1 : 32'h0);
            check($sformatf("%s wr_ctl c%0d", name, c),
                  {state_o, busy, done, wr_en, wr_addr, rd_addr0, rd_addr1},
                  {2'b01, 1'b1, 1'b0, 1'b1, 5'(c), 10'b0});
            check($sformatf("%s wr_data c%0d", name, c), wr_data, exp_wd);
         end else begin
            check($sformatf("%s rd c%0d", name, c),
                  {state_o, busy, done, wr_en, wr_addr, wr_data, rd_addr0, rd_addr1},
                  {2'b00, 1'b1, 1'b0, 1'b0, 5'b0, 32'b0, 5'(c - DEPTH), 5'(c - DEPTH + HALF)});
         end
      end
      @(negedge clk);
      start = 1'b0;
      check({name, " done_ctl"}, {state_o, busy, done, wr_en},
            {2'b10, 1'b0, 1'b1, 1'b0});
      check({name, " done_bus"}, {wr_addr, wr_data, rd_addr0, rd_addr1}, 64'h0);
      check({name, " err_cnt"}, err_cnt, exp_err);
      check({name, " fail_addr"}, fail_addr, exp_fail);
      check({name, " pass"}, pass, exp_err == 0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence followed by randomized runs
   // ---------------------------------------------------------------------------
   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      mode     = 2'b00;
      inj_en   = 1'b0;
      inj_addr = '0;
      clear_faults();
      for (int i = 0; i < DEPTH; i++) rf[i] = '0;

      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle");

      // Mode 00: decrementing seed pattern.
      run_test("mode00", 2'b00, 1'b0, 5'd0, 1'b0);
      check("mode00 rf0", rf[0], 32'hFFFF000F);
      check("mode00 rf31", rf[31], 32'hFFFEFFF0);

      // Mode 10: checkerboard, with start pulses while busy.
      run_test("mode10", 2'b10, 1'b0, 5'd0, 1'b1);
      check("mode10 rf4", rf[4], 32'hAAAAAAAA);
      check("mode10 rf5", rf[5], 32'h55555555);

      // Injected single-bit fault at address 20 (upper half of the sweep).
      run_test("inject", 2'b01, 1'b1, 5'd20, 1'b0);
      check("inject rf20", rf[20], 32'h15);

      // Restart from DONE with a clean run: the counters must clear.
      run_test("restart", 2'b11, 1'b0, 5'd0, 1'b1);

      // Bit 3 stuck at 0 on addresses 2 and 18: both ports of one read pair.
      s0_mask = 32'h8;
      fault_a = 5'd2;
      fault_b = 5'd18;
      run_test("stuck_chk", 2'b10, 1'b0, 5'd0, 1'b0);
      run_test("stuck_inc", 2'b01, 1'b0, 5'd0, 1'b0);
      clear_faults();

      // Every address mismatches: err_cnt reaches DEPTH without wrapping.
      fault_all = 1'b1;
      s1_mask   = 32'h8000_0000;
      run_test("all_bad", 2'b01, 1'b0, 5'd0, 1'b0);
      clear_faults();

      // Reset in the middle of WRITE, then a normal run.
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b01;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst wr_addr", {state_o, wr_en, wr_addr}, {2'b01, 1'b1, 5'd10});
      rst = 1'b1;
      @(negedge clk);
      check_idle("midrst");
      rst = 1'b0;
      run_test("after_rst", 2'b00, 1'b0, 5'd0, 1'b0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_idle("rst_prio");
      @(negedge clk);
      check("rst_prio hold", state_o, 2'b11);

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         clear_faults();
         if ($urandom_range(1) == 1) begin
            fault_a = 5'($urandom_range(DEPTH - 1));
            fault_b = 5'($urandom_range(DEPTH - 1));
            s0_mask = ($urandom_range(1) == 1) ? (32'h1 << $urandom_range(31)) : 32'h0;
            s1_mask = ($urandom_range(1) == 1) ? (32'h1 << $urandom_range(31)) : 32'h0;
         end
         run_test($sformatf("rand%0d", r), 2'($urandom_range(3)), 1'($urandom_range(1)),
                  5'($urandom_range(DEPTH - 1)), 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
